result_track_pipe: RTL and testbench
====================================

Name: result_track_pipe

Overview:
- Tracks the destination register, result data and write-enable of the six in-flight instructions younger than register read.
- Drives the m1..m6 forwarding inputs of the forwarding mux.
- Stalls a reader whose nearest producer has not yet produced its result.
- Retires slot 6 to the register-file write port.
- Sits between issue/execute and the forwarding mux; also owns the register-file writeback handshake.

Parameters:
- DATA_W, 16, width of result data.
- FLUSH_DEPTH, 2, number of youngest slots (including the issuing instruction) killed by flush_in; legal 1..6.

Ports:
- clk_in  in  1  clock, rising edge.
- rst_in  in  1  reset, asynchronous, active-high.
- issue_valid_in  in  1  an instruction enters slot 1 this cycle.
- issue_write_in  in  1  the issuing instruction writes a register.
- issue_num_in  in  3  destination register of the issuing instruction.
- issue_rdy_in  in  1  result is known at issue.
- issue_data_in  in  DATA_W  result when issue_rdy_in=1.
- late_valid_in  in  1  a late result is delivered (load/multi-cycle).
- late_slot_in  in  3  current slot (1..6) the late result belongs to.
- late_data_in  in  DATA_W  the late result.
- stall_in  in  1  freeze all slots.
- flush_in  in  1  kill younger instructions.
- src_a_num_in, src_b_num_in  in  3 each  reader source registers.
- num_m1_out..num_m6_out  out  3 each  slot k destination register.
- data_m1_out..data_m6_out  out  DATA_W each  slot k data.
- m1_write_out..m6_write_out  out  1 each  slot k write-enable.
- hazard_out  out  1  reader must stall; the nearest matching producer is not ready.
- wb_en_out  out  1  register-file write strobe.
- wb_num_out  out  3  register-file write register.
- wb_data_out  out  DATA_W  register-file write data.
- err_out  out  1  sticky; an unready result reached retirement.

Behaviour:
- Slot state: write, num, data, rdy per slot. Slot 1 is the youngest. Outputs are driven directly from the slot registers; mk_write_out=1 even when rdy=0.
- Reset (asynchronous): every slot clears write, num, data and rdy to 0. wb_en_out, wb_num_out, wb_data_out and err_out all go to 0. An in-flight instruction at reset is lost.
- Advance: when stall_in=0, at each edge slot k takes slot k-1 for k=2..6.
  - Slot 1 takes the issuing instruction if issue_valid_in=1 and the kill rule does not apply.
  - Otherwise slot 1 takes a bubble (write=0, rdy=0, num=0, data=0).
- Stall: when stall_in=1, no slot moves and the issuing instruction is ignored. The issuer must hold it.
- Late update: applies when late_valid_in=1, late_slot_in is in 1..6, and that slot has write=1.
  - The slot's data is set to late_data_in and rdy to 1.
  - The update targets the slot as it stands before this edge. If advancing, the updated entry lands in slot+1; if the slot is 6, the update lands in writeback.
  - Any other late_slot_in value, or a target with write=0, is ignored.
- Flush (applies regardless of stall): the issuing instruction plus the entries currently in slots 1..FLUSH_DEPTH-1 become bubbles.
  - Flush wins over a late update to a killed slot.
  - Flush wins over issue.
- Writeback: on an advance edge with slot 6 write=1 and rdy=1 (after any late update), the next cycle has wb_en_out=1, wb_num_out=slot 6 num, wb_data_out=slot 6 data.
  - Otherwise wb_en_out=0 next cycle, and wb_num_out/wb_data_out hold their previous values.
  - A stalled cycle always gives wb_en_out=0 next cycle.
- Error: on an advance edge with slot 6 write=1 and rdy=0 after any late update, err_out is set and stays set until reset. That writeback is suppressed.
- Hazard (combinational): for each source, find the lowest k with mk_write=1 and num_mk equal to the source.
  - If that slot has rdy=0, hazard_out=1.
  - Older ready matches are irrelevant.
  - Register 0 gets no special treatment.
- Simultaneous issue and late update: both take effect; they target different slots.

Test Plan:
- Reset mid-run: issue r3=0x1234 (rdy) for 3 cycles, then pulse rst_in asynchronously -> all m*_write_out, wb_en_out and err_out drop to 0 immediately.
- Ready issue: issue r5=0x00AA (rdy=1) with no stalls -> appears on m1 the next cycle and on m6 six cycles after issue; wb_en_out=1, wb_num_out=5, wb_data_out=0x00AA the cycle after that.
- Late update: issue r2 with rdy=0; src_a=2 -> hazard_out=1. Two cycles later send late_valid with slot 2, data 0xBEEF -> m3 shows 0xBEEF with rdy, hazard_out=0, and writeback 0xBEEF follows.
- Nearest producer wins: slot 1 holds r4 unready, slot 3 holds r4=0x0011 ready, src_b=4 -> hazard_out=1. Stall 2 cycles -> slots unchanged and wb_en_out=0.
- Flush: FLUSH_DEPTH=2, slots 1..3 hold r1, r2, r3, issue r6 with flush_in=1, no stall -> slots 1..3 become bubble, bubble, r2; r6 is never written back.
- Error: issue r7 with rdy=0 and no late result for 6 advances -> err_out=1 sticky, wb_en_out stays 0 for r7.

Source files
------------

// File: rtl/result_track_pipe.sv
// Six-deep in-flight result tracker: feeds the m1..m6 forwarding inputs, flags
// read-after-write hazards on unready producers and retires slot 6 to the register file.
module result_track_pipe #(
  parameter int DATA_W      = 16,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              issue_valid_in,
  input  logic              issue_write_in,
  input  logic [2:0]        issue_num_in,
  input  logic              issue_rdy_in,
  input  logic [DATA_W-1:0] issue_data_in,
  input  logic              late_valid_in,
  input  logic [2:0]        late_slot_in,
  input  logic [DATA_W-1:0] late_data_in,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic [2:0]        src_a_num_in,
  input  logic [2:0]        src_b_num_in,
  output logic [2:0]        num_m1_out,
  output logic [2:0]        num_m2_out,
  output logic [2:0]        num_m3_out,
  output logic [2:0]        num_m4_out,
  output logic [2:0]        num_m5_out,
  output logic [2:0]        num_m6_out,
  output logic [DATA_W-1:0] data_m1_out,
  output logic [DATA_W-1:0] data_m2_out,
  output logic [DATA_W-1:0] data_m3_out,
  output logic [DATA_W-1:0] data_m4_out,
  output logic [DATA_W-1:0] data_m5_out,
  output logic [DATA_W-1:0] data_m6_out,
  output logic              m1_write_out,
  output logic              m2_write_out,
  output logic              m3_write_out,
  output logic              m4_write_out,
  output logic              m5_write_out,
  output logic              m6_write_out,
  output logic              hazard_out,
  output logic              wb_en_out,
  output logic [2:0]        wb_num_out,
  output logic [DATA_W-1:0] wb_data_out,
  output logic              err_out
);

  // Index 0 is slot 1 (youngest), index 5 is slot 6 (retiring).
  logic [5:0]        write_q, write_d;
  logic [5:0]        rdy_q, rdy_d;
  logic [2:0]        num_q [6];
  logic [2:0]        num_d [6];
  logic [DATA_W-1:0] data_q [6];
  logic [DATA_W-1:0] data_d [6];

  logic [5:0]        upd_write, upd_rdy;
  logic [2:0]        upd_num [6];
  logic [DATA_W-1:0] upd_data [6];

  logic              wb_en_q, wb_en_d;
  logic [2:0]        wb_num_q, wb_num_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              err_q, err_d;

  // Slot contents as they stand this cycle after the late update and the flush kill.
  always_comb begin
    upd_write = write_q;
    upd_rdy   = rdy_q;
    for (int k = 0; k < 6; k++) begin
      upd_num[k]  = num_q[k];
      upd_data[k] = data_q[k];
      if (late_valid_in && late_slot_in == 3'(k + 1) && write_q[k]) begin
        upd_data[k] = late_data_in;
        upd_rdy[k]  = 1'b1;
      end
    end
    if (flush_in) begin
      for (int k = 0; k < FLUSH_DEPTH - 1; k++) begin
        upd_write[k] = 1'b0;
        upd_rdy[k]   = 1'b0;
        upd_num[k]   = '0;
        upd_data[k]  = '0;
      end
    end
  end

  always_comb begin
    write_d   = upd_write;
    rdy_d     = upd_rdy;
    wb_en_d   = 1'b0;
    wb_num_d  = wb_num_q;
    wb_data_d = wb_data_q;
    err_d     = err_q;
    for (int k = 0; k < 6; k++) begin
      num_d[k]  = upd_num[k];
      data_d[k] = upd_data[k];
    end
    if (!stall_in) begin
      for (int k = 1; k < 6; k++) begin
        write_d[k] = upd_write[k-1];
        rdy_d[k]   = upd_rdy[k-1];
        num_d[k]   = upd_num[k-1];
        data_d[k]  = upd_data[k-1];
      end
      if (issue_valid_in && !flush_in) begin
        write_d[0] = issue_write_in;
        rdy_d[0]   = issue_rdy_in;
        num_d[0]   = issue_num_in;
        data_d[0]  = issue_data_in;
      end else begin
        write_d[0] = 1'b0;
        rdy_d[0]   = 1'b0;
        num_d[0]   = '0;
        data_d[0]  = '0;
      end
      if (upd_write[5] && upd_rdy[5]) begin
        wb_en_d   = 1'b1;
        wb_num_d  = upd_num[5];
        wb_data_d = upd_data[5];
      end else if (upd_write[5]) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      write_q   <= '0;
      rdy_q     <= '0;
      for (int k = 0; k < 6; k++) begin
        num_q[k]  <= '0;
        data_q[k] <= '0;
      end
      wb_en_q   <= 1'b0;
      wb_num_q  <= '0;
      wb_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      write_q   <= write_d;
      rdy_q     <= rdy_d;
      for (int k = 0; k < 6; k++) begin
        num_q[k]  <= num_d[k];
        data_q[k] <= data_d[k];
      end
      wb_en_q   <= wb_en_d;
      wb_num_q  <= wb_num_d;
      wb_data_q <= wb_data_d;
      err_q     <= err_d;
    end
  end

  // Scanning oldest to youngest lets the nearest matching producer decide.
  logic hit_a, hit_b;
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int k = 5; k >= 0; k--) begin
      if (write_q[k] && num_q[k] == src_a_num_in) hit_a = !rdy_q[k];
      if (write_q[k] && num_q[k] == src_b_num_in) hit_b = !rdy_q[k];
    end
  end

  assign hazard_out  = hit_a | hit_b;
  assign wb_en_out   = wb_en_q;
  assign wb_num_out  = wb_num_q;
  assign wb_data_out = wb_data_q;
  assign err_out     = err_q;

  assign num_m1_out   = num_q[0];
  assign num_m2_out   = num_q[1];
  assign num_m3_out   = num_q[2];
  assign num_m4_out   = num_q[3];
  assign num_m5_out   = num_q[4];
  assign num_m6_out   = num_q[5];
  assign data_m1_out  = data_q[0];
  assign data_m2_out  = data_q[1];
  assign data_m3_out  = data_q[2];
  assign data_m4_out  = data_q[3];
  assign data_m5_out  = data_q[4];
  assign data_m6_out  = data_q[5];
  assign m1_write_out = write_q[0];
  assign m2_write_out = write_q[1];
  assign m3_write_out = write_q[2];
  assign m4_write_out = write_q[3];
  assign m5_write_out = write_q[4];
  assign m6_write_out = write_q[5];

endmodule

// File: tb/tb_result_track_pipe.sv
// Directed bench for result_track_pipe: one task per scenario, expected values
// hand-computed from the slot-advance, late-update, flush and writeback rules.
module tb_result_track_pipe;
  localparam int DATA_W = 16;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              issue_valid_in, issue_write_in, issue_rdy_in;
  logic [2:0]        issue_num_in;
  logic [DATA_W-1:0] issue_data_in;
  logic              late_valid_in;
  logic [2:0]        late_slot_in;
  logic [DATA_W-1:0] late_data_in;
  logic              stall_in, flush_in;
  logic [2:0]        src_a_num_in, src_b_num_in;
  logic [2:0]        num_m1_out, num_m2_out, num_m3_out, num_m4_out, num_m5_out, num_m6_out;
  logic [DATA_W-1:0] data_m1_out, data_m2_out, data_m3_out, data_m4_out, data_m5_out, data_m6_out;
  logic              m1_write_out, m2_write_out, m3_write_out, m4_write_out, m5_write_out, m6_write_out;
  logic              hazard_out, wb_en_out, err_out;
  logic [2:0]        wb_num_out;
  logic [DATA_W-1:0] wb_data_out;

  int nvec = 0;
  int nerr = 0;

  result_track_pipe #(.DATA_W(DATA_W), .FLUSH_DEPTH(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .issue_valid_in(issue_valid_in), .issue_write_in(issue_write_in),
    .issue_num_in(issue_num_in), .issue_rdy_in(issue_rdy_in), .issue_data_in(issue_data_in),
    .late_valid_in(late_valid_in), .late_slot_in(late_slot_in), .late_data_in(late_data_in),
    .stall_in(stall_in), .flush_in(flush_in),
    .src_a_num_in(src_a_num_in), .src_b_num_in(src_b_num_in),
    .num_m1_out(num_m1_out), .num_m2_out(num_m2_out), .num_m3_out(num_m3_out),
    .num_m4_out(num_m4_out), .num_m5_out(num_m5_out), .num_m6_out(num_m6_out),
    .data_m1_out(data_m1_out), .data_m2_out(data_m2_out), .data_m3_out(data_m3_out),
    .data_m4_out(data_m4_out), .data_m5_out(data_m5_out), .data_m6_out(data_m6_out),
    .m1_write_out(m1_write_out), .m2_write_out(m2_write_out), .m3_write_out(m3_write_out),
    .m4_write_out(m4_write_out), .m5_write_out(m5_write_out), .m6_write_out(m6_write_out),
    .hazard_out(hazard_out), .wb_en_out(wb_en_out), .wb_num_out(wb_num_out),
    .wb_data_out(wb_data_out), .err_out(err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic idle_inputs();
    issue_valid_in = 0; issue_write_in = 0; issue_rdy_in = 0;
    issue_num_in = 0; issue_data_in = 0;
    late_valid_in = 0; late_slot_in = 0; late_data_in = 0;
    stall_in = 0; flush_in = 0; src_a_num_in = 0; src_b_num_in = 0;
  endtask

  task automatic issue(input logic [2:0] num, input logic rdy, input logic [DATA_W-1:0] data);
    issue_valid_in = 1; issue_write_in = 1; issue_num_in = num;
    issue_rdy_in = rdy; issue_data_in = data;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_in = 1;
    tick(2);
    rst_in = 0;
  endtask

  task automatic test_reset();
    do_reset();
    nvec++; if ({m1_write_out, m2_write_out, m3_write_out, m4_write_out, m5_write_out, m6_write_out} !== 6'b0) begin nerr++; $display("FAIL reset_write got %b exp 0", {m1_write_out, m2_write_out, m3_write_out, m4_write_out, m5_write_out, m6_write_out}); end
    nvec++; if ({wb_en_out, err_out, hazard_out, wb_num_out, wb_data_out} !== '0) begin nerr++; $display("FAIL reset_wb got en=%b err=%b num=%0d data=%h exp all 0", wb_en_out, err_out, wb_num_out, wb_data_out); end
    issue(3'd3, 1'b1, 16'h1234);
    tick(3);
    nvec++; if (m3_write_out !== 1'b1 || data_m3_out !== 16'h1234) begin nerr++; $display("FAIL prereset_m3 got w=%b d=%h exp 1 1234", m3_write_out, data_m3_out); end
    issue_valid_in = 0;
    #2 rst_in = 1;
    #1;
    nvec++; if ({m1_write_out, m2_write_out, m3_write_out, m4_write_out, m5_write_out, m6_write_out, wb_en_out, err_out} !== 8'b0) begin nerr++; $display("FAIL async_reset got %b exp 0", {m1_write_out, m2_write_out, m3_write_out, m4_write_out, m5_write_out, m6_write_out, wb_en_out, err_out}); end
    nvec++; if (data_m1_out !== 16'h0 || num_m1_out !== 3'd0) begin nerr++; $display("FAIL async_reset_m1 got num=%0d data=%h exp 0 0", num_m1_out, data_m1_out); end
    #2 rst_in = 0;
    $display("test_reset done");
  endtask

  task automatic test_ready_issue();
    do_reset();
    issue(3'd5, 1'b1, 16'h00AA);
    tick();
    issue_valid_in = 0;
    nvec++; if (m1_write_out !== 1'b1 || num_m1_out !== 3'd5 || data_m1_out !== 16'h00AA) begin nerr++; $display("FAIL ready_m1 got w=%b n=%0d d=%h exp 1 5 00aa", m1_write_out, num_m1_out, data_m1_out); end
    tick(5);
    nvec++; if (m6_write_out !== 1'b1 || num_m6_out !== 3'd5 || data_m6_out !== 16'h00AA || wb_en_out !== 1'b0) begin nerr++; $display("FAIL ready_m6 got w=%b n=%0d d=%h wb=%b exp 1 5 00aa 0", m6_write_out, num_m6_out, data_m6_out, wb_en_out); end
    tick();
    nvec++; if (wb_en_out !== 1'b1 || wb_num_out !== 3'd5 || wb_data_out !== 16'h00AA) begin nerr++; $display("FAIL ready_wb got en=%b n=%0d d=%h exp 1 5 00aa", wb_en_out, wb_num_out, wb_data_out); end
    tick();
    nvec++; if (wb_en_out !== 1'b0 || wb_num_out !== 3'd5 || wb_data_out !== 16'h00AA) begin nerr++; $display("FAIL ready_wb_hold got en=%b n=%0d d=%h exp 0 5 00aa", wb_en_out, wb_num_out, wb_data_out); end
    $display("test_ready_issue done");
  endtask

  task automatic test_late_update();
    do_reset();
    issue(3'd2, 1'b0, 16'h0000);
    tick();
    issue_valid_in = 0;
    src_a_num_in = 3'd2;
    #1;
    nvec++; if (hazard_out !== 1'b1) begin nerr++; $display("FAIL late_hazard_s1 got %b exp 1", hazard_out); end
    tick();
    nvec++; if (hazard_out !== 1'b1 || m2_write_out !== 1'b1 || num_m2_out !== 3'd2) begin nerr++; $display("FAIL late_hazard_s2 got hz=%b w=%b n=%0d exp 1 1 2", hazard_out, m2_write_out, num_m2_out); end
    late_valid_in = 1; late_slot_in = 3'd2; late_data_in = 16'hBEEF;
    tick();
    late_valid_in = 0;
    nvec++; if (data_m3_out !== 16'hBEEF || m3_write_out !== 1'b1 || hazard_out !== 1'b0) begin nerr++; $display("FAIL late_m3 got d=%h w=%b hz=%b exp beef 1 0", data_m3_out, m3_write_out, hazard_out); end
    tick(4);
    nvec++; if (wb_en_out !== 1'b1 || wb_num_out !== 3'd2 || wb_data_out !== 16'hBEEF || err_out !== 1'b0) begin nerr++; $display("FAIL late_wb got en=%b n=%0d d=%h err=%b exp 1 2 beef 0", wb_en_out, wb_num_out, wb_data_out, err_out); end
    $display("test_late_update done");
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(3'd1, 1'b0, 16'h0000);
    tick();
    issue(3'd2, 1'b1, 16'h2222);
    late_valid_in = 1; late_slot_in = 3'd1; late_data_in = 16'h5555;
    tick();
    issue_valid_in = 0;
    src_a_num_in = 3'd1; src_b_num_in = 3'd2;
    #1;
    nvec++; if (num_m1_out !== 3'd2 || data_m1_out !== 16'h2222 || num_m2_out !== 3'd1 || data_m2_out !== 16'h5555) begin nerr++; $display("FAIL b2b_slots got m1=%0d/%h m2=%0d/%h exp 2/2222 1/5555", num_m1_out, data_m1_out, num_m2_out, data_m2_out); end
    nvec++; if (hazard_out !== 1'b0) begin nerr++; $display("FAIL b2b_hazard got %b exp 0", hazard_out); end
    late_slot_in = 3'd3; late_data_in = 16'h9999;
    tick();
    late_valid_in = 0;
    nvec++; if (m4_write_out !== 1'b0 || data_m4_out !== 16'h0000) begin nerr++; $display("FAIL late_to_bubble got w=%b d=%h exp 0 0000", m4_write_out, data_m4_out); end
    $display("test_back_to_back done");
  endtask

  task automatic test_nearest_and_stall();
    do_reset();
    issue(3'd5, 1'b1, 16'h0055); tick();
    issue_valid_in = 0;          tick(2);
    issue(3'd4, 1'b1, 16'h0011); tick();
    issue_valid_in = 0;          tick();
    issue(3'd4, 1'b0, 16'h0000); tick();
    src_b_num_in = 3'd4;
    issue(3'd1, 1'b1, 16'h0777);
    stall_in = 1;
    #1;
    nvec++; if (hazard_out !== 1'b1 || data_m3_out !== 16'h0011 || num_m6_out !== 3'd5) begin nerr++; $display("FAIL nearest_hazard got hz=%b m3=%h m6n=%0d exp 1 0011 5", hazard_out, data_m3_out, num_m6_out); end
    tick();
    nvec++; if (num_m1_out !== 3'd4 || m1_write_out !== 1'b1 || data_m3_out !== 16'h0011 || m2_write_out !== 1'b0 || wb_en_out !== 1'b0 || hazard_out !== 1'b1) begin nerr++; $display("FAIL stall1 got m1=%0d w=%b m3=%h m2w=%b wb=%b hz=%b exp 4 1 0011 0 0 1", num_m1_out, m1_write_out, data_m3_out, m2_write_out, wb_en_out, hazard_out); end
    issue_valid_in = 0;
    late_valid_in = 1; late_slot_in = 3'd1; late_data_in = 16'h4444;
    tick();
    late_valid_in = 0;
    nvec++; if (data_m1_out !== 16'h4444 || num_m1_out !== 3'd4 || hazard_out !== 1'b0 || wb_en_out !== 1'b0 || num_m6_out !== 3'd5) begin nerr++; $display("FAIL stall2 got m1=%h n=%0d hz=%b wb=%b m6n=%0d exp 4444 4 0 0 5", data_m1_out, num_m1_out, hazard_out, wb_en_out, num_m6_out); end
    stall_in = 0;
    tick();
    nvec++; if (wb_en_out !== 1'b1 || wb_num_out !== 3'd5 || wb_data_out !== 16'h0055 || num_m2_out !== 3'd4) begin nerr++; $display("FAIL unstall_wb got en=%b n=%0d d=%h m2n=%0d exp 1 5 0055 4", wb_en_out, wb_num_out, wb_data_out, num_m2_out); end
    $display("test_nearest_and_stall done");
  endtask

  task automatic test_flush();
    int wb_cnt;
    logic [2:0] wb_n [2];
    logic [DATA_W-1:0] wb_d [2];
    logic seen6;
    wb_cnt = 0; seen6 = 0;
    wb_n[0] = 0; wb_n[1] = 0; wb_d[0] = 0; wb_d[1] = 0;
    do_reset();
    issue(3'd3, 1'b1, 16'h0303); tick();
    issue(3'd2, 1'b1, 16'h0202); tick();
    issue(3'd1, 1'b1, 16'h0101); tick();
    issue(3'd6, 1'b1, 16'h0606);
    flush_in = 1;
    tick();
    flush_in = 0; issue_valid_in = 0;
    nvec++; if (m1_write_out !== 1'b0 || m2_write_out !== 1'b0 || m3_write_out !== 1'b1 || num_m3_out !== 3'd2 || num_m4_out !== 3'd3) begin nerr++; $display("FAIL flush_slots got w1=%b w2=%b w3=%b n3=%0d n4=%0d exp 0 0 1 2 3", m1_write_out, m2_write_out, m3_write_out, num_m3_out, num_m4_out); end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (wb_en_out) begin
        if (wb_num_out == 3'd6) seen6 = 1;
        if (wb_cnt < 2) begin wb_n[wb_cnt] = wb_num_out; wb_d[wb_cnt] = wb_data_out; end
        wb_cnt++;
      end
    end
    nvec++; if (seen6 !== 1'b0 || wb_cnt != 2) begin nerr++; $display("FAIL flush_wb_count got cnt=%0d r6=%b exp 2 0", wb_cnt, seen6); end
    nvec++; if (wb_n[0] !== 3'd3 || wb_d[0] !== 16'h0303 || wb_n[1] !== 3'd2 || wb_d[1] !== 16'h0202) begin nerr++; $display("FAIL flush_wb_order got %0d/%h %0d/%h exp 3/0303 2/0202", wb_n[0], wb_d[0], wb_n[1], wb_d[1]); end
    $display("test_flush done");
  endtask

  task automatic test_error();
    do_reset();
    issue(3'd7, 1'b0, 16'h0000);
    tick();
    issue_valid_in = 0;
    tick(5);
    nvec++; if (err_out !== 1'b0 || m6_write_out !== 1'b1 || num_m6_out !== 3'd7) begin nerr++; $display("FAIL err_before got err=%b w6=%b n6=%0d exp 0 1 7", err_out, m6_write_out, num_m6_out); end
    tick();
    nvec++; if (err_out !== 1'b1 || wb_en_out !== 1'b0) begin nerr++; $display("FAIL err_set got err=%b wb=%b exp 1 0", err_out, wb_en_out); end
    tick(3);
    nvec++; if (err_out !== 1'b1 || wb_en_out !== 1'b0) begin nerr++; $display("FAIL err_sticky got err=%b wb=%b exp 1 0", err_out, wb_en_out); end
    do_reset();
    nvec++; if (err_out !== 1'b0) begin nerr++; $display("FAIL err_clear got %b exp 0", err_out); end
    $display("test_error done");
  endtask

  initial begin
    rst_in = 1;
    idle_inputs();
    test_reset();
    test_ready_issue();
    test_late_update();
    test_back_to_back();
    test_nearest_and_stall();
    test_flush();
    test_error();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
